// File: rtl/uart_pkg.sv
// Shared constants and FSM state encoding for the UART transmit path.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_STROBE    = 3'd2,
    ST_WAIT_ACK  = 3'd3,
    ST_WAIT_DONE = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Host write port plus transmitter handshake seen by uart_tx_feeder.
interface uart_tx_feeder_if #(
  parameter int ADDR_W = 4
);
  import uart_pkg::*;

  logic              enable;
  logic              wr_en;
  logic [BYTE_W-1:0] wr_data;
  logic              clr_err;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              ack_err;
  logic [BYTE_W-1:0] Tx_DATA;
  logic              Tx_WR;
  logic              Tx_EN;
  logic              Tx_BUSY;

  // master: host plus transmitter; slave: the feeder itself
  modport master (
    output enable, wr_en, wr_data, clr_err, Tx_BUSY,
    input  full, empty, count, overflow, ack_err, Tx_DATA, Tx_WR, Tx_EN
  );

  modport slave (
    input  enable, wr_en, wr_data, clr_err, Tx_BUSY,
    output full, empty, count, overflow, ack_err, Tx_DATA, Tx_WR, Tx_EN
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// Circular byte buffer with a separate occupancy counter; full is judged
// before a same-cycle pop, so a write into a full FIFO is always dropped.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int WIDTH  = BYTE_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [ADDR_W:0]  count,
  output logic             full,
  output logic             empty
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Transmit buffer and write sequencer feeding uart_transmitter one byte per frame.
//
//   state      | meaning
//   IDLE       | wait for enable, queued byte and idle transmitter
//   LOAD       | pop FIFO head into Tx_DATA
//   STROBE     | Tx_WR high for this cycle only
//   WAIT_ACK   | wait for Tx_BUSY to rise, bounded by ACK_TIMEOUT
//   WAIT_DONE  | wait for Tx_BUSY to fall
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int ACK_TIMEOUT = 8
) (
  input logic              clk,
  input logic              reset,
  uart_tx_feeder_if.slave  bus
);

  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

  tx_state_e         state;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [BYTE_W-1:0] pop_data;
  logic [BYTE_W-1:0] tx_data;
  logic              tx_wr;
  logic              overflow;
  logic              ack_err;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;

  assign pop         = (state == ST_LOAD);
  assign bus.Tx_EN   = bus.enable;
  assign bus.Tx_DATA = tx_data;
  assign bus.Tx_WR   = tx_wr;
  assign bus.full    = fifo_full;
  assign bus.empty   = fifo_empty;
  assign bus.overflow = overflow;
  assign bus.ack_err  = ack_err;

  uart_sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .WIDTH  (BYTE_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (bus.wr_en),
    .push_data (bus.wr_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .count     (bus.count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      tmo_cnt  <= '0;
      tx_data  <= '0;
      tx_wr    <= 1'b0;
      overflow <= 1'b0;
      ack_err  <= 1'b0;
    end else begin
      tx_wr <= 1'b0;
      // clear first so a same-cycle error below takes priority
      if (bus.clr_err) begin
        overflow <= 1'b0;
        ack_err  <= 1'b0;
      end
      if (bus.wr_en && fifo_full) overflow <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (bus.enable && !fifo_empty && !bus.Tx_BUSY) state <= ST_LOAD;
        end
        ST_LOAD: begin
          tx_data <= pop_data;
          tx_wr   <= 1'b1;
          state   <= ST_STROBE;
        end
        ST_STROBE: begin
          tmo_cnt <= TMO_W'(ACK_TIMEOUT - 1);
          state   <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (bus.Tx_BUSY) begin
            state <= ST_WAIT_DONE;
          end else if (tmo_cnt == '0) begin
            // byte counts as consumed; no retry
            ack_err <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (!bus.Tx_BUSY) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
